// File: rtl/switch_input_sampler.sv
// Slide-switch front end: 2-FF synchronizer, per-bit counter debounce, and a
// valid/ready change-event record. Optional evt_count output under DBNC_EVT_COUNT_EN.
module switch_input_sampler #(
  parameter int N_SW        = 5,
  parameter int DBNC_CYCLES = 240000,
  parameter int CNT_W       = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_stable,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [N_SW-1:0] evt_snap,
  output logic [N_SW-1:0] evt_rise,
  output logic [N_SW-1:0] evt_fall,
  output logic            evt_ovf,
  input  logic            ovf_clr
`ifdef DBNC_EVT_COUNT_EN
  ,
  output logic [7:0]      evt_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

  logic [N_SW-1:0]  sync0_r;
  logic [N_SW-1:0]  sync1_r;
  logic [CNT_W-1:0] cnt_r      [N_SW];
  logic [CNT_W-1:0] cnt_next_s [N_SW];
  logic [N_SW-1:0]  stable_next_s;
  logic [N_SW-1:0]  chg_s;
  logic             evt_s;
  logic             xfer_s;
  logic             load_s;
  logic             ovf_set_s;

  // Two-stage synchronizer for the asynchronous switch pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_r <= {N_SW{1'b0}};
      sync1_r <= {N_SW{1'b0}};
    end else begin
      sync0_r <= sw_raw;
      sync1_r <= sync0_r;
    end
  end

  // Debounce next-state: a bit is accepted only after holding for the full window.
  always_comb begin
    stable_next_s = sw_stable;
    for (int i = 0; i < N_SW; i++) begin
      cnt_next_s[i] = cnt_r[i];
      if (sync1_r[i] == sw_stable[i]) begin
        cnt_next_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_next_s[i] = sync1_r[i];
        cnt_next_s[i]    = {CNT_W{1'b0}};
      end else begin
        cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Event and handshake qualifiers; a transfer frees the slot for a same-edge load.
  always_comb begin
    chg_s     = stable_next_s ^ sw_stable;
    evt_s     = |chg_s;
    xfer_s    = evt_valid & evt_ready;
    load_s    = evt_s & (~evt_valid | evt_ready);
    ovf_set_s = evt_s & evt_valid & ~evt_ready;
  end

  // Debounce counters and published stable levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_stable <= {N_SW{1'b0}};
      for (int i = 0; i < N_SW; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      sw_stable <= stable_next_s;
      for (int i = 0; i < N_SW; i++) cnt_r[i] <= cnt_next_s[i];
    end
  end

  // Event record register; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_snap  <= {N_SW{1'b0}};
      evt_rise  <= {N_SW{1'b0}};
      evt_fall  <= {N_SW{1'b0}};
    end else if (load_s) begin
      evt_valid <= 1'b1;
      evt_snap  <= stable_next_s;
      evt_rise  <= chg_s & stable_next_s;
      evt_fall  <= chg_s & ~stable_next_s;
    end else if (xfer_s) begin
      evt_valid <= 1'b0;
    end else begin
      evt_valid <= evt_valid;
    end
  end

  // Sticky overflow flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_ovf <= 1'b0;
    end else if (ovf_set_s) begin
      evt_ovf <= 1'b1;
    end else if (ovf_clr) begin
      evt_ovf <= 1'b0;
    end else begin
      evt_ovf <= evt_ovf;
    end
  end

`ifdef DBNC_EVT_COUNT_EN
  // Saturating count of accepted records; clear beats a simultaneous transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_count <= 8'd0;
    end else if (ovf_clr) begin
      evt_count <= 8'd0;
    end else if (xfer_s && (evt_count != 8'd255)) begin
      evt_count <= evt_count + 8'd1;
    end else begin
      evt_count <= evt_count;
    end
  end
`endif

endmodule

// File: tb/tb_switch_input_sampler.sv
// Directed bench for switch_input_sampler with DBNC_CYCLES=8; define
// DBNC_EVT_COUNT_EN to also exercise evt_count.
module tb_switch_input_sampler;

  localparam int N_SW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] sw_stable;
  logic            evt_valid;
  logic            evt_ready;
  logic [N_SW-1:0] evt_snap;
  logic [N_SW-1:0] evt_rise;
  logic [N_SW-1:0] evt_fall;
  logic            evt_ovf;
  logic            ovf_clr;
`ifdef DBNC_EVT_COUNT_EN
  logic [7:0]      evt_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  switch_input_sampler #(.N_SW(N_SW), .DBNC_CYCLES(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_snap  (evt_snap),
    .evt_rise  (evt_rise),
    .evt_fall  (evt_fall),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
`ifdef DBNC_EVT_COUNT_EN
    ,
    .evt_count (evt_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sw;
    logic       rdy;
    logic       clr;
    int         n;
    logic [4:0] e_stable;
    logic       e_valid;
    logic [4:0] e_snap;
    logic [4:0] e_rise;
    logic [4:0] e_fall;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {10'd0, sw_stable, evt_valid, evt_snap, evt_rise, evt_fall, evt_ovf};
  endfunction

  function automatic logic [31:0] pack(input logic [4:0] st, input logic v, input logic [4:0] sn,
                                       input logic [4:0] r, input logic [4:0] f, input logic o);
    return {10'd0, st, v, sn, r, f, o};
  endfunction

  initial begin
    // sw, rdy, clr, edges, stable, valid, snap, rise, fall, ovf
    vecs[0]  = '{5'b00000, 1'b0, 1'b0,  3, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[1]  = '{5'b00001, 1'b0, 1'b0,  9, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[2]  = '{5'b00001, 1'b0, 1'b0,  1, 5'b00001, 1'b1, 5'b00001, 5'b00001, 5'b00000, 1'b0};
    vecs[3]  = '{5'b00001, 1'b1, 1'b0,  1, 5'b00001, 1'b0, 5'b00001, 5'b00001, 5'b00000, 1'b0};
    vecs[4]  = '{5'b00101, 1'b1, 1'b0,  5, 5'b00001, 1'b0, 5'b00001, 5'b00001, 5'b00000, 1'b0};
    vecs[5]  = '{5'b00001, 1'b1, 1'b0, 12, 5'b00001, 1'b0, 5'b00001, 5'b00001, 5'b00000, 1'b0};
    vecs[6]  = '{5'b00000, 1'b1, 1'b0, 10, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00001, 1'b0};
    vecs[7]  = '{5'b00000, 1'b1, 1'b0,  1, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00001, 1'b0};
    vecs[8]  = '{5'b10001, 1'b1, 1'b0,  9, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00001, 1'b0};
    vecs[9]  = '{5'b10001, 1'b1, 1'b0,  1, 5'b10001, 1'b1, 5'b10001, 5'b10001, 5'b00000, 1'b0};
    vecs[10] = '{5'b10001, 1'b1, 1'b0,  1, 5'b10001, 1'b0, 5'b10001, 5'b10001, 5'b00000, 1'b0};
    vecs[11] = '{5'b10000, 1'b1, 1'b0, 10, 5'b10000, 1'b1, 5'b10000, 5'b00000, 5'b00001, 1'b0};
    vecs[12] = '{5'b10000, 1'b1, 1'b0,  1, 5'b10000, 1'b0, 5'b10000, 5'b00000, 5'b00001, 1'b0};
    vecs[13] = '{5'b10010, 1'b0, 1'b0, 10, 5'b10010, 1'b1, 5'b10010, 5'b00010, 5'b00000, 1'b0};
    vecs[14] = '{5'b10110, 1'b0, 1'b0, 10, 5'b10110, 1'b1, 5'b10010, 5'b00010, 5'b00000, 1'b1};
    vecs[15] = '{5'b10110, 1'b0, 1'b1,  1, 5'b10110, 1'b1, 5'b10010, 5'b00010, 5'b00000, 1'b0};
    vecs[16] = '{5'b11110, 1'b0, 1'b0,  9, 5'b10110, 1'b1, 5'b10010, 5'b00010, 5'b00000, 1'b0};
    vecs[17] = '{5'b11110, 1'b0, 1'b1,  1, 5'b11110, 1'b1, 5'b10010, 5'b00010, 5'b00000, 1'b1};
    vecs[18] = '{5'b11110, 1'b1, 1'b0,  1, 5'b11110, 1'b0, 5'b10010, 5'b00010, 5'b00000, 1'b1};
    vecs[19] = '{5'b11110, 1'b0, 1'b1,  1, 5'b11110, 1'b0, 5'b10010, 5'b00010, 5'b00000, 1'b0};

    // Reset state with switches already high: nothing may propagate.
    rst_n     = 1'b0;
    sw_raw    = 5'b11111;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_state", outs(), 32'd0);
`ifdef DBNC_EVT_COUNT_EN
    chk("reset_count", {24'd0, evt_count}, 32'd0);
`endif
    sw_raw = 5'b00000;
    rst_n  = 1'b1;

    for (int i = 0; i < 20; i++) begin
      sw_raw    = vecs[i].sw;
      evt_ready = vecs[i].rdy;
      ovf_clr   = vecs[i].clr;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), outs(),
          pack(vecs[i].e_stable, vecs[i].e_valid, vecs[i].e_snap,
               vecs[i].e_rise, vecs[i].e_fall, vecs[i].e_ovf));
    end
    ovf_clr = 1'b0;

    // Reset mid-debounce (count 5 on bit0), then all switches held high.
    sw_raw    = 5'b11111;
    evt_ready = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("post_reset_wait", outs(), 32'd0);
    @(posedge clk);
    #1;
    chk("post_reset_evt", outs(), pack(5'b11111, 1'b1, 5'b11111, 5'b11111, 5'b00000, 1'b0));

`ifdef DBNC_EVT_COUNT_EN
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("count_one", {24'd0, evt_count}, 32'd1);
    for (int k = 0; k < 300; k++) begin
      sw_raw = sw_raw ^ 5'b00001;
      repeat (11) @(posedge clk);
    end
    #1;
    chk("count_sat", {24'd0, evt_count}, 32'd255);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    chk("count_clr", {24'd0, evt_count}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_input_sampler.md
Name: switch_input_sampler

Overview:
- Input-side companion to the board's switch-to-LED gate logic: reads the raw slide switches on the Vaman FPGA board and turns them into clean, registered signals.
- Per switch: 2-FF synchronization, then a counter-based debounce.
- Publishes the debounced vector continuously.
- Also emits a change-event record (snapshot plus rise/fall masks) over a valid/ready handshake, so downstream gate logic or a UART/LED reporter sees every settled switch change.

Parameters:
- N_SW, 5, number of switch inputs.
- DBNC_CYCLES, 240000, clock cycles a new level must hold before it is accepted (20 ms at 12 MHz); minimum 2.
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W >= DBNC_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  N_SW  raw switch pins; asynchronous to clk.
- sw_stable  output  N_SW  debounced switch levels.
- evt_valid  output  1  change-event record pending.
- evt_ready  input  1  consumer accepts the record.
- evt_snap  output  N_SW  sw_stable value at the time of the event.
- evt_rise  output  N_SW  bits that went 0->1 in this event.
- evt_fall  output  N_SW  bits that went 1->0 in this event.
- evt_ovf  output  1  sticky: an event was dropped while a record was pending.
- ovf_clr  input  1  synchronous clear of evt_ovf.
- evt_count  output  8  saturating count of accepted events; present only with DBNC_EVT_COUNT_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Sync flops, sw_stable, all counters, evt_valid, evt_snap, evt_rise, evt_fall and evt_ovf go to 0.
  - Reset mid-debounce discards the partial count.
  - After release, a switch held high is reported as a 0->1 event once debounced.
- Synchronizer: two flops per bit. s1 is the second stage.
- Debounce, per bit i, independent counter cnt[i]:
  - If s1[i] == sw_stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DBNC_CYCLES-1: sw_stable[i] <= s1[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Glitch shorter than the window: the counter clears and sw_stable does not change.
- Latency: a pin level that holds from the sampling edge (edge 0) appears on sw_stable after edge DBNC_CYCLES+1.
- Event detect:
  - chg = stable_next XOR sw_stable, evaluated combinationally for the current edge.
  - An event occurs when chg != 0.
  - Several bits settling on the same edge form a single event.
- Handshake:
  - Transfer occurs when evt_valid && evt_ready.
  - When evt_valid is high and evt_ready low, evt_snap/evt_rise/evt_fall hold stable.
  - Event while !evt_valid, or on the same cycle as a transfer: load evt_snap = stable_next, evt_rise = chg & stable_next, evt_fall = chg & ~stable_next; evt_valid <= 1 next edge (back-to-back, no bubble).
  - Transfer with no event: evt_valid <= 0.
  - Event while evt_valid && !evt_ready: the record is unchanged and evt_ovf <= 1. The newest level is still visible on sw_stable.
  - evt_valid never depends combinationally on evt_ready.
- Overflow: evt_ovf is sticky until ovf_clr. If ovf_clr and a new overflow occur on the same cycle, set wins.
- No combinational path from any input to any output. All outputs are registered.

Optional Feature:
- Macro: DBNC_EVT_COUNT_EN.
- Defined:
  - Adds the evt_count output.
  - evt_count increments by 1 on each handshake transfer and saturates at 255.
  - ovf_clr also clears evt_count; on the same cycle as a transfer, clear wins.
  - Reset value 0.
- Undefined:
  - The port and its counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Settled single change: DBNC_CYCLES=8, sw_raw 00000->00001 held.
  - sw_stable=00001 after edge 9.
  - One record: evt_snap=00001, evt_rise=00001, evt_fall=0.
- Glitch rejection: DBNC_CYCLES=8, bit2 pulsed high for 5 cycles.
  - sw_stable unchanged, evt_valid stays 0.
- Simultaneous bits: bits 0 and 4 set together, bit0 later cleared.
  - First record: evt_rise=10001.
  - Second record: evt_fall=00001.
  - Consumer has evt_ready tied 1 throughout: evt_valid pulses once per event.
- Backpressure and overflow: evt_ready=0, two separate settled changes.
  - The first record is held unchanged and evt_ovf=1.
  - ovf_clr pulse -> evt_ovf=0.
  - ovf_clr on the same cycle as a third dropped event -> evt_ovf stays 1.
- Reset mid-operation: assert rst_n low at debounce count 5.
  - All outputs go to 0 immediately.
  - After release, switches held 11111 -> one event with evt_rise=11111 after DBNC_CYCLES+1 edges.
- With DBNC_EVT_COUNT_EN defined: 300 accepted events -> evt_count=255; ovf_clr -> 0.
